// File: rtl/gray_2_bin_seq.sv
// ----------------------------------------------------------------------------
// gray_2_bin_seq
// Sequential Gray-to-binary converter. A captured Gray word is resolved one
// bit per clock, MSB first, then held in DONE until the consumer takes it.
//
// Optional feature (macro GRAY2BIN_SEQ_CHK_EN): flags seq_err when an
// accepted word is not exactly one bit away from the previously accepted
// word. Without the macro seq_err is tied low and no history is kept.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   gray_in holds a word to convert
//   in_ready   out  block can accept a word (IDLE)
//   gray_in    in   Gray-coded input word [WIDTH]
//   out_valid  out  bin_out holds a completed result (DONE)
//   out_ready  in   downstream accepts the result
//   bin_out    out  binary result [WIDTH]
//   busy       out  high in DECODE and DONE
//   seq_err    out  sequence-check flag, valid with out_valid
// ----------------------------------------------------------------------------
module gray_2_bin_seq #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] gray_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] bin_out,
   output logic             busy,
   output logic             seq_err
);

   localparam int unsigned   KW    = $clog2(WIDTH);
   localparam logic [KW-1:0] K_TOP = KW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_DONE   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] g_q, g_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic             accept_c;
   logic             err_flag;

   assign accept_c = (state_q == S_IDLE) && in_valid;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (in_valid)          state_d = S_DECODE;
         S_DECODE: if (k_q == '0)         state_d = S_DONE;
         S_DONE:   if (out_ready)         state_d = S_IDLE;
         default:                         state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from the state register
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      seq_err   = 1'b0;
      unique case (state_q)
         S_IDLE:   in_ready = 1'b1;
         S_DECODE: busy     = 1'b1;
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            seq_err   = err_flag;
         end
         default: in_ready = 1'b1;
      endcase
   end

   // Datapath: bit k of the binary word is the XOR of Gray bits k..MSB,
   // which equals bin[k+1] ^ g[k] with unresolved bits still at 0.
   always_comb begin
      g_d   = g_q;
      k_d   = k_q;
      bin_d = bin_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               g_d   = gray_in;
               k_d   = K_TOP;
               bin_d = '0;
            end
         end
         S_DECODE: begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
               if (k_q == KW'(i)) bin_d[i] = ^(g_q >> i);
            end
            if (k_q != '0) k_d = k_q - KW'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_q   <= '0;
         k_q   <= K_TOP;
         bin_q <= '0;
      end else begin
         g_q   <= g_d;
         k_q   <= k_d;
         bin_q <= bin_d;
      end
   end

   assign bin_out = bin_q;

`ifdef GRAY2BIN_SEQ_CHK_EN
   logic [WIDTH-1:0] prev_q, prev_d;
   logic             prev_vld_q, prev_vld_d;
   logic             err_q, err_d;

   // True when exactly one bit of x is set
   function automatic logic single_bit(input logic [WIDTH-1:0] x);
      int unsigned cnt;
      cnt = 0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt = cnt + 32'(x[i]);
      return (cnt == 1);
   endfunction

   // Compare against the previous accepted word; first word never flags
   always_comb begin
      prev_d     = prev_q;
      prev_vld_d = prev_vld_q;
      err_d      = err_q;
      if (accept_c) begin
         prev_d     = gray_in;
         prev_vld_d = 1'b1;
         err_d      = prev_vld_q && !single_bit(gray_in ^ prev_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         prev_vld_q <= prev_vld_d;
         err_q      <= err_d;
      end
   end

   assign err_flag = err_q;
`else
   logic unused_accept;
   assign unused_accept = accept_c;
   assign err_flag      = 1'b0;
`endif

endmodule

// File: tb/tb_gray_2_bin_seq.sv
// ----------------------------------------------------------------------------
// tb_gray_2_bin_seq
// Directed bench for gray_2_bin_seq at WIDTH=5. Expectations follow the
// GRAY2BIN_SEQ_CHK_EN macro when it is defined for the build.
// ----------------------------------------------------------------------------
module tb_gray_2_bin_seq;

   localparam int unsigned W = 5;
`ifdef GRAY2BIN_SEQ_CHK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] gray_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] bin_out;
   logic         busy;
   logic         seq_err;

   int n_checks;
   int n_fail;

   gray_2_bin_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .gray_in   (gray_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bin_out   (bin_out),
      .busy      (busy),
      .seq_err   (seq_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Offer a word, wait (bounded) for acceptance, then for out_valid.
   // lat = edges from acceptance to out_valid, -1 on timeout.
   task automatic send(input logic [W-1:0] g, output int lat);
      logic acc;
      acc      = 1'b0;
      lat      = -1;
      in_valid = 1'b1;
      gray_in  = g;
      for (int c = 0; c < 20 && !acc; c++) begin
         acc = in_ready;
         tick();
      end
      in_valid = 1'b0;
      n_checks++;
      if (acc !== 1'b1) begin
         $display("FAIL send_accept: word %b never accepted", g);
         n_fail++;
      end else begin
         for (int c = 1; c <= 20; c++) begin
            tick();
            if (out_valid === 1'b1) begin
               lat = c;
               break;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      gray_in   = '0;
      #2;
      n_checks++;
      if ({in_ready, out_valid, busy, seq_err} !== 4'b1000 || bin_out !== 5'd0) begin
         $display("FAIL reset_state: rdy=%b ov=%b busy=%b err=%b bin=%b, required 1 0 0 0 00000",
                  in_ready, out_valid, busy, seq_err, bin_out);
         n_fail++;
      end
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_all_ones();
      logic [W-1:0] part [W];
      int lat;
      part = '{5'b10000, 5'b10000, 5'b10100, 5'b10100, 5'b10101};
      out_ready = 1'b1;
      in_valid  = 1'b1;
      gray_in   = 5'b11111;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if ({in_ready, busy} !== 2'b01 || bin_out !== 5'd0) begin
         $display("FAIL ones_accept: rdy=%b busy=%b bin=%b, required 0 1 00000", in_ready, busy, bin_out);
         n_fail++;
      end
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c <= int'(W)) begin
            n_checks++;
            if (bin_out !== part[c-1]) begin
               $display("FAIL ones_partial: edge %0d bin=%b, required %b", c, bin_out, part[c-1]);
               n_fail++;
            end
         end
         if (out_valid === 1'b1) begin
            lat = c;
            break;
         end
      end
      n_checks++;
      if (lat != int'(W)) begin
         $display("FAIL ones_latency: got %0d, required %0d", lat, W);
         n_fail++;
      end
      n_checks++;
      if (bin_out !== 5'd21 || seq_err !== 1'b0 || in_ready !== 1'b0) begin
         $display("FAIL ones_result: bin=%0d err=%b rdy=%b, required 21 0 0", bin_out, seq_err, in_ready);
         n_fail++;
      end
      tick();
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         $display("FAIL ones_return_idle: rdy=%b ov=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
         n_fail++;
      end
   endtask

   task automatic test_backpressure();
      logic ov_seen;
      ov_seen   = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      gray_in   = 5'b01101;
      tick();
      // Garbage on the input side while decoding must be ignored
      gray_in = 5'b10000;
      for (int c = 0; c < 20 && !ov_seen; c++) begin
         tick();
         ov_seen = out_valid;
      end
      in_valid = 1'b0;
      n_checks++;
      if (ov_seen !== 1'b1) begin
         $display("FAIL bp_out_valid: timeout waiting for out_valid");
         n_fail++;
      end
      for (int c = 0; c < 4; c++) begin
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || bin_out !== 5'd9 || seq_err !== CHK) begin
            $display("FAIL bp_hold: cycle %0d ov=%b rdy=%b bin=%0d err=%b, required 1 0 9 %b",
                     c, out_valid, in_ready, bin_out, seq_err, CHK);
            n_fail++;
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         $display("FAIL bp_release: rdy=%b ov=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
         n_fail++;
      end
   endtask

   task automatic test_seq_check();
      logic [W-1:0] words [3];
      logic [W-1:0] exp_b [3];
      logic         exp_e [3];
      int lat;
      words = '{5'b01101, 5'b01100, 5'b11111};
      exp_b = '{5'd9, 5'd8, 5'd21};
      exp_e = '{1'b0, 1'b0, CHK};
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(words[i], lat);
         n_checks++;
         if (lat != int'(W) || bin_out !== exp_b[i] || seq_err !== exp_e[i]) begin
            $display("FAIL seq_word%0d: lat=%0d bin=%0d err=%b, required %0d %0d %b",
                     i, lat, bin_out, seq_err, W, exp_b[i], exp_e[i]);
            n_fail++;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic acc;
      logic ov_seen;
      int   lat;
      acc      = 1'b0;
      ov_seen  = 1'b0;
      in_valid = 1'b1;
      gray_in  = 5'b11111;
      for (int c = 0; c < 20 && !acc; c++) begin
         acc = in_ready;
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, out_valid, busy, seq_err} !== 4'b1000 || bin_out !== 5'd0) begin
         $display("FAIL midreset_state: rdy=%b ov=%b busy=%b err=%b bin=%b, required 1 0 0 0 00000",
                  in_ready, out_valid, busy, seq_err, bin_out);
         n_fail++;
      end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (out_valid === 1'b1) ov_seen = 1'b1;
      end
      n_checks++;
      if (ov_seen !== 1'b0) begin
         $display("FAIL midreset_no_output: out_valid=%b after reset, required 0", ov_seen);
         n_fail++;
      end
      send(5'b00001, lat);
      n_checks++;
      if (lat != int'(W) || bin_out !== 5'b00001 || seq_err !== 1'b0) begin
         $display("FAIL midreset_next: lat=%0d bin=%b err=%b, required %0d 00001 0", lat, bin_out, seq_err, W);
         n_fail++;
      end
   endtask

   task automatic test_sweep();
      logic [W-1:0] b;
      logic [W-1:0] g;
      int lat;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         b = W'(i);
         g = b ^ (b >> 1);
         send(g, lat);
         n_checks++;
         if (lat != int'(W) || bin_out !== b || seq_err !== 1'b0) begin
            $display("FAIL sweep_%0d: gray=%b lat=%0d bin=%b err=%b, required %0d %b 0",
                     i, g, lat, bin_out, seq_err, W, b);
            n_fail++;
         end
      end
   endtask

   // in_valid held high: accepts must be exactly W+2 cycles apart
   task automatic test_back_to_back();
      int prev_idx;
      int n_acc;
      int n_done;
      prev_idx  = -1;
      n_acc     = 0;
      n_done    = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      gray_in   = 5'b00000;
      for (int c = 0; c < 30; c++) begin
         tick();
         n_checks++;
         if (in_ready === 1'b1 && out_valid === 1'b1) begin
            $display("FAIL b2b_ready_and_valid: both high at cycle %0d", c);
            n_fail++;
         end
         if (in_ready === 1'b1) begin
            if (prev_idx >= 0) begin
               n_checks++;
               if (c - prev_idx != int'(W) + 2) begin
                  $display("FAIL b2b_interval: got %0d, required %0d", c - prev_idx, W + 2);
                  n_fail++;
               end
            end
            prev_idx = c;
            n_acc++;
         end
         if (out_valid === 1'b1) begin
            n_checks++;
            // First word differs by one bit from the last sweep code (10000);
            // later words repeat and must flag when the check is built in.
            if (bin_out !== 5'd0 || seq_err !== (n_done == 0 ? 1'b0 : CHK)) begin
               $display("FAIL b2b_zero_result%0d: bin=%b err=%b, required 00000 %b",
                        n_done, bin_out, seq_err, (n_done == 0 ? 1'b0 : CHK));
               n_fail++;
            end
            n_done++;
         end
      end
      in_valid = 1'b0;
      n_checks++;
      if (n_acc < 3 || n_done < 3) begin
         $display("FAIL b2b_count: accepts=%0d results=%0d, required at least 3 each", n_acc, n_done);
         n_fail++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_all_ones();
      test_backpressure();
      test_seq_check();
      test_reset_mid();
      test_sweep();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
